// File: rtl/multicycle_main_control_if.sv
// ============================================================================
// Module      : multicycle_main_control_if
// Description : Bundle between the multicycle main control FSM and the
//               datapath: opcode / memory handshake in, controls out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_main_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic [1:0]       pc_source;
  logic             alu_op1;
  logic             alu_op2;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic             reg_write;
  logic             reg_dst;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;

  // Controller side
  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, pc_source, alu_op1, alu_op2, alu_src_a, alu_src_b,
           reg_write, reg_dst, illegal_op, instr_count
  );

  // Datapath side
  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, pc_source, alu_op1, alu_op2, alu_src_a, alu_src_b,
           reg_write, reg_dst, illegal_op, instr_count
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_main_control.sv
// ============================================================================
// Module      : multicycle_main_control
// Description : Moore main control FSM for the multicycle MIPS datapath with
//               memory-ready stalls and a retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_main_control #(
  parameter int CNT_W = 32
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  multicycle_main_control_if.master  bus
);

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_R_WB     = 4'd8,
    S_EXEC_I   = 4'd9,
    S_I_WB     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_ERROR    = 4'd13
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_retire;
  logic [CNT_W-1:0] r_count;

  // Registered control outputs, loaded for the state being entered
  logic       r_fetch;
  logic       r_pc_write;
  logic       r_pc_write_cond;
  logic       r_i_or_d;
  logic       r_mem_read;
  logic       r_mem_write;
  logic       r_mem_to_reg;
  logic [1:0] r_pc_source;
  logic [1:0] r_alu_op;
  logic       r_alu_src_a;
  logic [1:0] r_alu_src_b;
  logic       r_reg_write;
  logic       r_reg_dst;
  logic       r_illegal;

  // Next-state decode; opcode only matters in DECODE and MEM_ADDR
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     w_next = S_FETCH;
      S_FETCH:    if (bus.mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          c_OP_LW, c_OP_SW: w_next = S_MEM_ADDR;
          c_OP_RTYPE:       w_next = S_EXEC_R;
          c_OP_ADDI:        w_next = S_EXEC_I;
          c_OP_BEQ:         w_next = S_BRANCH;
          c_OP_J:           w_next = S_JUMP;
          default:          w_next = S_ERROR;
        endcase
      end
      S_MEM_ADDR: w_next = (bus.opcode == c_OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (bus.mem_ready) w_next = S_MEM_WB;
      S_MEM_WR:   if (bus.mem_ready) w_next = S_FETCH;
      S_EXEC_R:   w_next = S_R_WB;
      S_EXEC_I:   w_next = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: w_next = S_FETCH;
      S_ERROR:    w_next = S_ERROR;
      default:    w_next = S_IDLE;
    endcase
  end

  // An instruction retires when a terminal state hands back to FETCH
  assign w_retire = (w_next == S_FETCH) && (r_state != S_IDLE) && (r_state != S_FETCH);

  // State, counter and Moore outputs registered from the next state
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_count         <= '0;
      r_fetch         <= 1'b0;
      r_pc_write      <= 1'b0;
      r_pc_write_cond <= 1'b0;
      r_i_or_d        <= 1'b0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_to_reg    <= 1'b0;
      r_pc_source     <= 2'b00;
      r_alu_op        <= 2'b00;
      r_alu_src_a     <= 1'b0;
      r_alu_src_b     <= 2'b00;
      r_reg_write     <= 1'b0;
      r_reg_dst       <= 1'b0;
      r_illegal       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_count <= r_count + CNT_W'(1);
      r_fetch         <= 1'b0;
      r_pc_write      <= 1'b0;
      r_pc_write_cond <= 1'b0;
      r_i_or_d        <= 1'b0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_to_reg    <= 1'b0;
      r_pc_source     <= 2'b00;
      r_alu_op        <= 2'b00;
      r_alu_src_a     <= 1'b0;
      r_alu_src_b     <= 2'b00;
      r_reg_write     <= 1'b0;
      r_reg_dst       <= 1'b0;
      r_illegal       <= 1'b0;
      case (w_next)
        S_FETCH: begin
          r_fetch     <= 1'b1;
          r_mem_read  <= 1'b1;
          r_alu_src_b <= 2'b01;
        end
        S_DECODE:   r_alu_src_b <= 2'b11;
        S_MEM_ADDR: begin
          r_alu_src_a <= 1'b1;
          r_alu_src_b <= 2'b10;
        end
        S_MEM_RD: begin
          r_mem_read <= 1'b1;
          r_i_or_d   <= 1'b1;
        end
        S_MEM_WB: begin
          r_reg_write  <= 1'b1;
          r_mem_to_reg <= 1'b1;
        end
        S_MEM_WR: begin
          r_mem_write <= 1'b1;
          r_i_or_d    <= 1'b1;
        end
        S_EXEC_R: begin
          r_alu_src_a <= 1'b1;
          r_alu_op    <= 2'b10;
        end
        S_R_WB: begin
          r_reg_write <= 1'b1;
          r_reg_dst   <= 1'b1;
        end
        S_EXEC_I: begin
          r_alu_src_a <= 1'b1;
          r_alu_src_b <= 2'b10;
        end
        S_I_WB:     r_reg_write <= 1'b1;
        S_BRANCH: begin
          r_alu_src_a     <= 1'b1;
          r_alu_op        <= 2'b01;
          r_pc_write_cond <= 1'b1;
          r_pc_source     <= 2'b01;
        end
        S_JUMP: begin
          r_pc_write  <= 1'b1;
          r_pc_source <= 2'b10;
        end
        S_ERROR:    r_illegal <= 1'b1;
        default: ;
      endcase
    end
  end

  // IR load and PC increment in FETCH only fire on the cycle memory delivers
  assign bus.ir_write      = r_fetch & bus.mem_ready;
  assign bus.pc_write      = r_pc_write | (r_fetch & bus.mem_ready);
  assign bus.pc_write_cond = r_pc_write_cond;
  assign bus.i_or_d        = r_i_or_d;
  assign bus.mem_read      = r_mem_read;
  assign bus.mem_write     = r_mem_write;
  assign bus.mem_to_reg    = r_mem_to_reg;
  assign bus.pc_source     = r_pc_source;
  assign bus.alu_op1       = r_alu_op[1];
  assign bus.alu_op2       = r_alu_op[0];
  assign bus.alu_src_a     = r_alu_src_a;
  assign bus.alu_src_b     = r_alu_src_b;
  assign bus.reg_write     = r_reg_write;
  assign bus.reg_dst       = r_reg_dst;
  assign bus.illegal_op    = r_illegal;
  assign bus.instr_count   = r_count;

endmodule

`default_nettype wire
